// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial WIDTH-bit adder/subtractor, one full-adder cell plus carry flop
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             s_bit;
   logic             c_next;
   logic [WIDTH-1:0] res_next;
   logic             last_bit;

   always_comb begin
      s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
      c_next   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
      // New bit enters from the MSB side so the LSB-first stream lands in place.
      res_next = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
      last_bit = (cnt_q == CW'(WIDTH - 1));

      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SHIFT;
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               res_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_SHIFT: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = c_next;
            cnt_d   = cnt_q + CW'(1);
            res_d   = res_next;
            if (last_bit) begin
               // carry_q here is the carry into the MSB.
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sum_d   = res_next;
               cout_d  = c_next;
               ovf_d   = carry_q ^ c_next;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
